// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: the bubble instruction and the {pc, instruction} entry layout.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_mem.sv
// Entry storage for the fetch queue: synchronous write, asynchronous read, no reset.
module fetch_buffer_mem #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fetch_buffer.sv
// Fetch-to-decode queue of {pc, instruction} pairs with decode stall and branch flush.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int               XLEN  = 32,
  parameter int               ILEN  = 32,
  parameter int               DEPTH = 4,
  parameter logic [ILEN-1:0]  NOP   = ILEN'(NOP_INSTR),
  localparam int              PW    = $clog2(DEPTH),
  localparam int              CW    = $clog2(DEPTH + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            fetch_valid,
  output logic            fetch_ready,
  input  logic [XLEN-1:0] pc_fetch,
  input  logic [ILEN-1:0] instruction_fetch,
  input  logic            stall,
  input  logic            br_taken,
  output logic            decode_valid,
  output logic [XLEN-1:0] pc_decode,
  output logic [ILEN-1:0] instruction_decode,
  output logic [CW-1:0]   count
);

  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic [XLEN+ILEN-1:0] w_head;

  // Full comes from the count so a full queue is distinguishable from an empty one.
  assign w_full       = (r_count == CW'(DEPTH));
  assign fetch_ready  = ~w_full & ~br_taken;
  assign decode_valid = (r_count != '0);
  assign w_push       = fetch_valid & fetch_ready & ~br_taken;
  assign w_pop        = decode_valid & ~stall & ~br_taken;
  assign count        = r_count;

  fetch_buffer_mem #(
    .WIDTH (XLEN + ILEN),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock     (clock),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data ({pc_fetch, instruction_fetch}),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_head)
  );

  assign pc_decode          = decode_valid ? w_head[XLEN+ILEN-1:ILEN] : '0;
  assign instruction_decode = decode_valid ? w_head[ILEN-1:0] : NOP;

  // A flush drops everything queued and discards any push or pop in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (br_taken) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_fetch_buffer;
  import fetch_pkg::*;

  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clock;
  logic            reset;
  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] pc_fetch;
  logic [ILEN-1:0] instruction_fetch;
  logic            stall;
  logic            br_taken;
  logic            decode_valid;
  logic [XLEN-1:0] pc_decode;
  logic [ILEN-1:0] instruction_decode;
  logic [CW-1:0]   count;

  int nCompared   = 0;
  int nMismatched = 0;
  bit monEn       = 0;

  fetch_entry_t expQ[$];

  fetch_buffer #(
    .XLEN  (XLEN),
    .ILEN  (ILEN),
    .DEPTH (DEPTH)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .fetch_valid        (fetch_valid),
    .fetch_ready        (fetch_ready),
    .pc_fetch           (pc_fetch),
    .instruction_fetch  (instruction_fetch),
    .stall              (stall),
    .br_taken           (br_taken),
    .decode_valid       (decode_valid),
    .pc_decode          (pc_decode),
    .instruction_decode (instruction_decode),
    .count              (count)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the model queue holds what decode should see; a consumed head is popped.
  always @(negedge clock) begin
    if (monEn) begin
      checkOutput("count", 64'(count), 64'(expQ.size()));
      checkOutput("decode_valid", 64'(decode_valid), 64'(expQ.size() != 0));
      checkOutput("fetch_ready", 64'(fetch_ready), 64'(expQ.size() < DEPTH && !br_taken));
      if (expQ.size() != 0) begin
        checkOutput("pc_decode", 64'(pc_decode), 64'(expQ[0].pc));
        checkOutput("instruction_decode", 64'(instruction_decode), 64'(expQ[0].instruction));
        if (!stall && !br_taken) void'(expQ.pop_front());
      end else begin
        checkOutput("empty_pc", 64'(pc_decode), 64'd0);
        checkOutput("empty_instr", 64'(instruction_decode), 64'(NOP_INSTR));
      end
    end
  end

  // Called at posedge+1; acceptance is judged on the occupancy before this cycle's pop.
  task automatic applyStimulus(input bit fv, input logic [31:0] pcv, input logic [31:0] iv,
                               input bit st, input bit br);
    bit accepted;
    fetch_valid       = fv;
    pc_fetch          = pcv;
    instruction_fetch = iv;
    stall             = st;
    br_taken          = br;
    accepted = fv && !br && (expQ.size() < DEPTH);
    @(negedge clock);
    #1;
    if (br) expQ.delete();
    else if (accepted) expQ.push_back('{pc: pcv, instruction: iv});
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset             = 0;
    fetch_valid       = 0;
    pc_fetch          = '0;
    instruction_fetch = '0;
    stall             = 0;
    br_taken          = 0;
    #12;
    checkOutput("reset_count", 64'(count), 64'd0);
    checkOutput("reset_valid", 64'(decode_valid), 64'd0);
    checkOutput("reset_pc", 64'(pc_decode), 64'd0);
    checkOutput("reset_instr", 64'(instruction_decode), 64'(NOP_INSTR));
    #3 reset = 1;
    #1;
    checkOutput("ready_after_reset", 64'(fetch_ready), 64'd1);
    @(posedge clock);
    #1;
    monEn = 1;

    // Single entry then bubble
    applyStimulus(1, 32'h0, 32'h00500093, 0, 0);
    checkOutput("single_valid", 64'(decode_valid), 64'd1);
    checkOutput("single_instr", 64'(instruction_decode), 64'h00500093);
    applyStimulus(0, 32'h0, 32'h0, 0, 0);
    checkOutput("bubble_instr", 64'(instruction_decode), 64'(NOP_INSTR));

    // Fill under stall; fifth push must be refused
    for (int i = 0; i < 5; i++) applyStimulus(1, 32'(i * 4), 32'hA000_0000 + 32'(i), 1, 0);
    checkOutput("full_count", 64'(count), 64'd4);
    checkOutput("full_ready", 64'(fetch_ready), 64'd0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 32'h0, 32'h0, 0, 0);

    // Streaming: one push and one pop every cycle across pointer wrap
    for (int i = 0; i < 10; i++) applyStimulus(1, 32'(i * 4), 32'hB000_0000 + 32'(i), 0, 0);
    checkOutput("stream_count", 64'(count), 64'd1);
    applyStimulus(0, 32'h0, 32'h0, 0, 0);

    // Flush with a concurrent push, then refill
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'h20 + 32'(i * 4), 32'hC000_0000 + 32'(i), 1, 0);
    applyStimulus(1, 32'h40, 32'hC000_0040, 0, 1);
    checkOutput("flush_count", 64'(count), 64'd0);
    checkOutput("flush_valid", 64'(decode_valid), 64'd0);
    applyStimulus(1, 32'h80, 32'hC000_0080, 0, 0);
    checkOutput("refill_pc", 64'(pc_decode), 64'h80);
    applyStimulus(0, 32'h0, 32'h0, 0, 0);

    // Asynchronous reset between edges
    for (int i = 0; i < 2; i++) applyStimulus(1, 32'h100 + 32'(i * 4), 32'hD000_0000 + 32'(i), 1, 0);
    fetch_valid = 0;
    checkOutput("pre_reset_count", 64'(count), 64'd2);
    #1 reset = 0;
    #1;
    checkOutput("async_reset_count", 64'(count), 64'd0);
    checkOutput("async_reset_valid", 64'(decode_valid), 64'd0);
    checkOutput("async_reset_instr", 64'(instruction_decode), 64'(NOP_INSTR));
    expQ.delete();
    reset = 1;
    applyStimulus(0, 32'h0, 32'h0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(($urandom % 4) != 0, {$urandom, 2'b00} & 32'hFFFF_FFFC, $urandom,
                    ($urandom % 3) == 0, ($urandom % 16) == 0);
    end
    applyStimulus(0, 32'h0, 32'h0, 0, 0);

    monEn = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
